// File: rtl/mul_accumulator.sv
// Packet accumulator for signed multiplier products: sums up to LEN beats into a
// wide signed accumulator and presents sum, term count and overflow downstream.
module mul_accumulator #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned LEN   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             dst_valid,
  input  logic             dst_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       acc_count,
  output logic             overflow
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] acc_out_q, acc_out_d;
  logic [7:0]       acc_count_q, acc_count_d;
  logic             overflow_q, overflow_d;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] sum;
  logic [7:0]       cnt_inc;
  logic             ovf_beat;
  logic             accept;

  assign src_ready = (state_q == ACCUM);
  assign dst_valid = (state_q == HOLD);
  assign acc_out   = acc_out_q;
  assign acc_count = acc_count_q;
  assign overflow  = overflow_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    acc_out_d   = acc_out_q;
    acc_count_d = acc_count_q;
    overflow_d  = overflow_q;

    ext      = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
    sum      = acc_q + ext;
    cnt_inc  = cnt_q + 8'd1;
    // Same-sign operands producing a differently-signed sum means wraparound.
    ovf_beat = (acc_q[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
    accept   = src_valid && (state_q == ACCUM);

    case (state_q)
      ACCUM: begin
        if (accept) begin
          acc_d = sum;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | ovf_beat;
          if (in_last || (cnt_inc == 8'(LEN))) begin
            acc_out_d   = sum;
            acc_count_d = cnt_inc;
            overflow_d  = ovf_q | ovf_beat;
            state_d     = HOLD;
          end
        end
      end
      HOLD: begin
        if (dst_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_out_q   <= '0;
      acc_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      acc_out_q   <= acc_out_d;
      acc_count_q <= acc_count_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule
